// File: rtl/interp_row_sequencer.sv
// Row upscaler sequencer: drives a vector ALU lane so that N source pixels
// become 3N-2 output pixels. Each adjacent pair p[i], p[i+1] yields p[i] and
// the two one-third interpolants; the row closes with the final pixel.
module interp_row_sequencer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W-1:0] length,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [2:0]        alu_op,
  output logic              alu_vcsub,
  input  logic [31:0]       alu_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    E0,
    E1,
    E2,
    LAST,
    FIN
  } state_t;

  localparam logic [2:0] OP_PASS   = 3'b000;
  localparam logic [2:0] OP_INTERP = 3'b100;

  state_t state_q, state_d;

  logic [DATA_W-1:0] cur_q, nxt_q;
  logic [ADDR_W-1:0] i_q, k_q;
  logic [ADDR_W-1:0] src_q, dst_q, len_q;
  logic              rej_q;

  logic              len_ok;
  logic              more_pairs;
  logic [31:0]       cur_ext, nxt_ext;
  logic [31:DATA_W]  alu_out_unused;

  assign len_ok     = (length >= ADDR_W'(2));
  assign more_pairs = (({1'b0, i_q} + (ADDR_W+1)'(2)) < {1'b0, len_q});
  assign cur_ext    = {{(32-DATA_W){1'b0}}, cur_q};
  assign nxt_ext    = {{(32-DATA_W){1'b0}}, nxt_q};

  // Only the low pixel bits of the ALU result are meaningful
  assign wr_data        = alu_out[DATA_W-1:0];
  assign alu_out_unused = alu_out[31:DATA_W];
  assign alu_vcsub      = 1'b0;

  // State register; reset aborts any row in flight straight back to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: latch the row on accept, track pixel pair and write count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q <= '0;
      nxt_q <= '0;
      i_q   <= '0;
      k_q   <= '0;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      rej_q <= 1'b0;
    end else begin
      rej_q <= 1'b0;
      case (state_q)
        IDLE: begin
          rej_q <= start && !len_ok;
          if (start && len_ok) begin
            src_q <= src_base;
            dst_q <= dst_base;
            len_q <= length;
            i_q   <= '0;
            k_q   <= '0;
          end
        end
        RD1: begin
          cur_q <= rd_data;
        end
        E0: begin
          nxt_q <= rd_data;
          k_q   <= k_q + ADDR_W'(1);
        end
        E1: begin
          k_q <= k_q + ADDR_W'(1);
        end
        E2: begin
          cur_q <= nxt_q;
          i_q   <= i_q + ADDR_W'(1);
          k_q   <= k_q + ADDR_W'(1);
        end
        LAST: begin
          k_q <= k_q + ADDR_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and Moore output decode; everything idles at zero by default
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    rd_addr = '0;
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = OP_PASS;
    wr_en   = 1'b0;
    wr_addr = '0;
    busy    = 1'b0;
    done    = rej_q;
    err     = rej_q;
    case (state_q)
      IDLE: begin
        if (start && len_ok) begin
          state_d = RD0;
        end
      end
      RD0: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = src_q;
        state_d = RD1;
      end
      RD1: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = src_q + ADDR_W'(1);
        state_d = E0;
      end
      E0: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = dst_q + k_q;
        alu_a   = cur_ext;
        state_d = E1;
      end
      E1: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = dst_q + k_q;
        alu_a   = cur_ext;
        alu_b   = nxt_ext;
        alu_op  = OP_INTERP;
        state_d = E2;
      end
      E2: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = dst_q + k_q;
        alu_a   = nxt_ext;
        alu_b   = cur_ext;
        alu_op  = OP_INTERP;
        if (more_pairs) begin
          rd_en   = 1'b1;
          rd_addr = src_q + i_q + ADDR_W'(2);
          state_d = E0;
        end else begin
          state_d = LAST;
        end
      end
      LAST: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = dst_q + k_q;
        alu_a   = cur_ext;
        state_d = FIN;
      end
      FIN: begin
        done    = 1'b1;
        err     = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
